el2_dccm_sram_responder: RTL and testbench
==========================================

// Module: el2_dccm_sram_responder
// PURPOSE
// - Sink-side (SRAM-end) responder for the DCCM half of the VeeR memory interface.
// - Holds banked DCCM data+ECC storage: accepts per-bank clock-enable/write/address from the core, returns dout/ecc after READ_LAT cycles.
// - Includes a one-shot error-injection FSM that corrupts read data in flight, so single- and double-bit ECC paths can be exercised.
// - Instantiated in the testbench/FPGA memory wrapper behind the DCCM sink signals.
// PARAMETERS
// - DCCM_NUM_BANKS   4   number of independent single-port banks
// - DCCM_DATA_WIDTH  32  data bits per bank word
// - DCCM_ECC_WIDTH   7   ECC bits per bank word
// - DCCM_INDEX_W     10  per-bank word address width (depth = 2**DCCM_INDEX_W)
// - READ_LAT         1   read latency in cycles, legal 1..3
// - FW = DCCM_DATA_WIDTH+DCCM_ECC_WIDTH (localparam), BW = $clog2(DCCM_NUM_BANKS), IW = $clog2(FW)
// PORTS
// - clk                in   1                 single clock; all state on posedge clk
// - rst                in   1                 synchronous, active-high reset
// - dccm_clken         in   NB                per-bank access enable
// - dccm_wren_bank     in   NB                per-bank write (valid only with clken)
// - dccm_addr_bank     in   NB x DCCM_INDEX_W  per-bank word address
// - dccm_wr_data_bank  in   NB x DATA         per-bank write data
// - dccm_wr_ecc_bank   in   NB x ECC          per-bank write ECC
// - dccm_bank_dout     out  NB x DATA         per-bank read data
// - dccm_bank_ecc      out  NB x ECC          per-bank read ECC
// - err_inj_arm        in   1                 pulse: arm one injection
// - err_inj_bank       in   BW                target bank, sampled with arm
// - err_inj_bit        in   IW                bit index in {ecc,data} word (data = LSBs), sampled with arm
// - err_inj_double     in   1                 1 = also flip bit (err_inj_bit+1) mod FW
// - err_inj_busy       out  1                 high in ARMED
// - err_inj_done       out  1                 one-cycle pulse when corrupted word is launched
// BEHAVIOUR
// - Reset: dout/ecc outputs, all pipeline stages, busy, done = 0; FSM -> IDLE. Storage array is NOT reset.
// - Write: clken[b]&wren[b] -> mem[b][addr] <= {ecc,data} at that edge; dout[b] unchanged.
// - Read: clken[b]&!wren[b] at edge N -> word visible on dout[b]/ecc[b] after edge N+READ_LAT-1 (READ_LAT=1: valid in cycle N+1).
// - Read pipeline is per bank, one valid bit per stage; stages shift every cycle (no stall).
// - Outputs hold the last delivered read word until a newer read emerges (SRAM hold semantics); writes and idle cycles never disturb them.
// - Back-to-back reads: one word per cycle per bank, in order; banks are fully independent; all banks may access in the same cycle.
// - Read of a never-written address returns X in simulation; no guarantee for synthesis.
// - clken=0: wren, addr and data ignored.
// - Error injection FSM states:
//   IDLE  -> ARMED on err_inj_arm; captures bank/bit/double
//   ARMED -> IDLE on the first read (clken&!wren) to captured bank; XOR mask applied to that word at read launch; done pulses next cycle
// - Arm pulse is ignored in ARMED; a read in the same cycle as arm is not corrupted.
// - Mask: single flips bit; double flips bit and (bit+1)%FW (bit=FW-1 wraps to bit 0). Stored array is never corrupted.
// - err_inj_bit >= FW: injection still consumes the read but flips nothing (mask 0).
// - Corrupted word traverses the same READ_LAT pipeline as normal data.
// - rst mid-operation: in-flight reads discarded (outputs return to 0); ARMED cancelled without done; stored contents retained.
// TESTING
// - READ_LAT=1: write bank0 addr 5 data 0xDEADBEEF ecc 0x2A; read next cycle -> dout[0]=0xDEADBEEF, ecc[0]=0x2A one cycle after read.
// - READ_LAT=3: reads to bank2 addrs 1,2,3 on consecutive cycles -> data returns in order on 3 consecutive cycles, first 3 cycles after first read; hold afterwards.
// - All 4 banks write and read simultaneously with distinct data -> no cross-bank interference; bank1 write during bank0 read leaves dout[1] unchanged.
// - Arm bank1 bit 3 single; read bank0 then bank1 word 0x0 -> bank0 clean, bank1 dout=0x8, done pulses once, busy drops; re-read gives 0x0.
// - Arm bank3 bit FW-1=38 double on word 0 -> ecc[3]=0x40, dout[3]=0x1; second arm while ARMED ignored.
// - Arm, then rst before any read, then read -> no corruption, no done; rst with reads in flight -> outputs 0, stored data still readable.

Source files
------------

// File: rtl/el2_dccm_sram_responder_if.sv
// DCCM sink-side bus bundle between the core (master) and the banked SRAM
// responder (slave).
//   dccm_clken        master->slave  per-bank access enable
//   dccm_wren_bank    master->slave  per-bank write strobe (qualified by clken)
//   dccm_addr_bank    master->slave  per-bank word address
//   dccm_wr_data_bank master->slave  per-bank write data
//   dccm_wr_ecc_bank  master->slave  per-bank write ECC
//   dccm_bank_dout    slave->master  per-bank read data
//   dccm_bank_ecc     slave->master  per-bank read ECC
interface el2_dccm_sram_responder_if #(
  parameter int NB = 4,
  parameter int DW = 32,
  parameter int EW = 7,
  parameter int AW = 10
);
  logic [NB-1:0]         dccm_clken;
  logic [NB-1:0]         dccm_wren_bank;
  logic [NB-1:0][AW-1:0] dccm_addr_bank;
  logic [NB-1:0][DW-1:0] dccm_wr_data_bank;
  logic [NB-1:0][EW-1:0] dccm_wr_ecc_bank;
  logic [NB-1:0][DW-1:0] dccm_bank_dout;
  logic [NB-1:0][EW-1:0] dccm_bank_ecc;

  modport master (
    output dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
    input  dccm_bank_dout, dccm_bank_ecc
  );

  modport slave (
    input  dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
    output dccm_bank_dout, dccm_bank_ecc
  );
endinterface

// File: rtl/el2_dccm_sram_responder.sv
// Banked DCCM data+ECC storage seen from the SRAM end of the memory interface.
// Each bank is an independent single-port array; reads return {ecc,data}
// READ_LAT cycles after the access edge and the outputs hold the last word
// delivered. A one-shot injector can XOR a one- or two-bit mask into the next
// read of a chosen bank so the core's ECC correct/detect paths get exercised.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   bus               DCCM sink bundle (slave modport)
//   err_inj_arm       pulse: arm one injection (ignored while armed)
//   err_inj_bank      target bank, sampled with arm
//   err_inj_bit       bit index into {ecc,data}, sampled with arm
//   err_inj_double    also flip bit (err_inj_bit+1) mod FW
//   err_inj_busy      injection armed and waiting for a read
//   err_inj_done      one-cycle pulse after the corrupted word launches
module el2_dccm_sram_responder #(
  parameter int DCCM_NUM_BANKS  = 4,
  parameter int DCCM_DATA_WIDTH = 32,
  parameter int DCCM_ECC_WIDTH  = 7,
  parameter int DCCM_INDEX_W    = 10,
  parameter int READ_LAT        = 1,
  localparam int FW = DCCM_DATA_WIDTH + DCCM_ECC_WIDTH,
  localparam int BW = (DCCM_NUM_BANKS > 1) ? $clog2(DCCM_NUM_BANKS) : 1,
  localparam int IW = $clog2(FW)
) (
  input  logic                   clk,
  input  logic                   rst,
  el2_dccm_sram_responder_if.slave bus,
  input  logic                   err_inj_arm,
  input  logic [BW-1:0]          err_inj_bank,
  input  logic [IW-1:0]          err_inj_bit,
  input  logic                   err_inj_double,
  output logic                   err_inj_busy,
  output logic                   err_inj_done
);

  localparam int NB    = DCCM_NUM_BANKS;
  localparam int DW    = DCCM_DATA_WIDTH;
  localparam int DEPTH = 1 << DCCM_INDEX_W;

  // Out-of-range bit index yields an empty mask; bit FW-1 doubles into bit 0.
  function automatic logic [FW-1:0] inj_mask_f(input logic [IW-1:0] bit_i, input logic dbl_i);
    logic [FW-1:0] m;
    int            b;
    int            n;
    b = int'(bit_i);
    n = (b == FW - 1) ? 0 : b + 1;
    m = '0;
    for (int i = 0; i < FW; i++) begin
      m[i] = (b == i) || (dbl_i && (n == i));
    end
    return m;
  endfunction

  typedef enum logic {S_IDLE, S_ARMED} inj_state_e;

  inj_state_e    state_q, state_d;
  logic [BW-1:0] bank_q, bank_d;
  logic [IW-1:0] bit_q, bit_d;
  logic          dbl_q, dbl_d;
  logic          done_q, done_d;
  logic [NB-1:0] rd_launch;
  logic [NB-1:0] inj_hit;
  logic [FW-1:0] inj_mask;

  assign inj_mask     = inj_mask_f(bit_q, dbl_q);
  assign err_inj_busy = (state_q == S_ARMED);
  assign err_inj_done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      bit_q   <= '0;
      dbl_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      bit_q   <= bit_d;
      dbl_q   <= dbl_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    bit_d   = bit_q;
    dbl_d   = dbl_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (err_inj_arm) begin
          state_d = S_ARMED;
          bank_d  = err_inj_bank;
          bit_d   = err_inj_bit;
          dbl_d   = err_inj_double;
        end
      end
      S_ARMED: begin
        if (|inj_hit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [FW-1:0] mem_q [DEPTH];
    logic [FW-1:0] rd_word;
    logic [FW-1:0] out_q;

    assign rd_launch[b] = bus.dccm_clken[b] & ~bus.dccm_wren_bank[b];
    assign inj_hit[b]   = (state_q == S_ARMED) && (bank_q == BW'(b)) && rd_launch[b];
    // The mask is applied only to the launched copy; the array keeps the clean word.
    assign rd_word      = mem_q[bus.dccm_addr_bank[b]] ^ (inj_hit[b] ? inj_mask : '0);

    always_ff @(posedge clk) begin
      if (bus.dccm_clken[b] & bus.dccm_wren_bank[b]) begin
        mem_q[bus.dccm_addr_bank[b]] <= {bus.dccm_wr_ecc_bank[b], bus.dccm_wr_data_bank[b]};
      end
    end

    if (READ_LAT == 1) begin : g_lat1
      // Stage p0 is the output register itself.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q <= '0;
        end else if (rd_launch[b]) begin
          out_q <= rd_word;
        end
      end
    end else begin : g_latn
      logic [FW-1:0]       data_p [READ_LAT-1];
      logic [READ_LAT-2:0] vld_p;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p <= '0;
          out_q <= '0;
          for (int k = 0; k < READ_LAT - 1; k++) begin
            data_p[k] <= '0;
          end
        end else begin
          // Stage p0: capture launched word
          vld_p[0] <= rd_launch[b];
          if (rd_launch[b]) begin
            data_p[0] <= rd_word;
          end
          // Stages p1..: plain shift, no stall
          for (int k = 1; k < READ_LAT - 1; k++) begin
            vld_p[k]  <= vld_p[k-1];
            data_p[k] <= data_p[k-1];
          end
          // Output stage: update only on a valid word, otherwise hold
          if (vld_p[READ_LAT-2]) begin
            out_q <= data_p[READ_LAT-2];
          end
        end
      end
    end

    assign bus.dccm_bank_dout[b] = out_q[DW-1:0];
    assign bus.dccm_bank_ecc[b]  = out_q[FW-1:DW];
  end

endmodule

// File: tb/tb_el2_dccm_sram_responder.sv
// Directed bench: one instance at READ_LAT=1 (storage, hold, bank isolation,
// error injection, reset) and one at READ_LAT=3 (pipeline ordering/latency,
// reset with reads in flight).
module tb_el2_dccm_sram_responder;
  localparam int NB = 4;
  localparam int DW = 32;
  localparam int EW = 7;
  localparam int AW = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm1, dbl1, busy1, done1;
  logic [1:0] bank1;
  logic [5:0] bit1;
  logic       arm3, dbl3, busy3, done3;
  logic [1:0] bank3;
  logic [5:0] bit3;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] vals [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};

  always #5 clk = ~clk;

  el2_dccm_sram_responder_if #(.NB(NB), .DW(DW), .EW(EW), .AW(AW)) bus1 ();
  el2_dccm_sram_responder_if #(.NB(NB), .DW(DW), .EW(EW), .AW(AW)) bus3 ();

  el2_dccm_sram_responder #(
    .DCCM_NUM_BANKS(NB), .DCCM_DATA_WIDTH(DW), .DCCM_ECC_WIDTH(EW),
    .DCCM_INDEX_W(AW), .READ_LAT(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .err_inj_arm(arm1), .err_inj_bank(bank1), .err_inj_bit(bit1),
    .err_inj_double(dbl1), .err_inj_busy(busy1), .err_inj_done(done1)
  );

  el2_dccm_sram_responder #(
    .DCCM_NUM_BANKS(NB), .DCCM_DATA_WIDTH(DW), .DCCM_ECC_WIDTH(EW),
    .DCCM_INDEX_W(AW), .READ_LAT(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .err_inj_arm(arm3), .err_inj_bank(bank3), .err_inj_bit(bit3),
    .err_inj_double(dbl3), .err_inj_busy(busy3), .err_inj_done(done3)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus1.dccm_clken     = '0;
    bus1.dccm_wren_bank = '0;
    bus3.dccm_clken     = '0;
    bus3.dccm_wren_bank = '0;
    arm1                = 1'b0;
  endtask

  task automatic wr1(input logic [1:0] b, input logic [9:0] a, input logic [31:0] d, input logic [6:0] e);
    bus1.dccm_clken[b]        = 1'b1;
    bus1.dccm_wren_bank[b]    = 1'b1;
    bus1.dccm_addr_bank[b]    = a;
    bus1.dccm_wr_data_bank[b] = d;
    bus1.dccm_wr_ecc_bank[b]  = e;
  endtask

  task automatic rd1(input logic [1:0] b, input logic [9:0] a);
    bus1.dccm_clken[b]     = 1'b1;
    bus1.dccm_wren_bank[b] = 1'b0;
    bus1.dccm_addr_bank[b] = a;
  endtask

  task automatic arm(input logic [1:0] b, input logic [5:0] bt, input logic d);
    arm1  = 1'b1;
    bank1 = b;
    bit1  = bt;
    dbl1  = d;
  endtask

  task automatic rd3(input logic [9:0] a);
    bus3.dccm_clken[2]     = 1'b1;
    bus3.dccm_wren_bank[2] = 1'b0;
    bus3.dccm_addr_bank[2] = a;
  endtask

  initial begin
    bus1.dccm_addr_bank = '0; bus1.dccm_wr_data_bank = '0; bus1.dccm_wr_ecc_bank = '0;
    bus3.dccm_addr_bank = '0; bus3.dccm_wr_data_bank = '0; bus3.dccm_wr_ecc_bank = '0;
    idle();
    bank1 = '0; bit1 = '0; dbl1 = 1'b0;
    arm3 = 1'b0; bank3 = '0; bit3 = '0; dbl3 = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    for (int b = 0; b < NB; b++) begin
      check_eq("rst_dout", 64'(bus1.dccm_bank_dout[b]), 64'h0);
      check_eq("rst_ecc", 64'(bus1.dccm_bank_ecc[b]), 64'h0);
      check_eq("rst_dout3", 64'(bus3.dccm_bank_dout[b]), 64'h0);
    end
    check_eq("rst_busy", 64'(busy1), 64'h0);
    check_eq("rst_done", 64'(done1), 64'h0);
    check_eq("rst_busy3", 64'(busy3), 64'h0);

    // Basic write then read, latency 1, hold
    wr1(2'd0, 10'd5, 32'hDEADBEEF, 7'h2A); step(); idle();
    check_eq("wr_keeps_dout", 64'(bus1.dccm_bank_dout[0]), 64'h0);
    rd1(2'd0, 10'd5); step(); idle();
    check_eq("rd_data", 64'(bus1.dccm_bank_dout[0]), 64'hDEADBEEF);
    check_eq("rd_ecc", 64'(bus1.dccm_bank_ecc[0]), 64'h2A);
    step();
    check_eq("rd_hold", 64'(bus1.dccm_bank_dout[0]), 64'hDEADBEEF);

    // All banks at once
    for (int b = 0; b < NB; b++) wr1(2'(b), 10'd7, vals[b], 7'(b + 1));
    step(); idle();
    for (int b = 0; b < NB; b++) rd1(2'(b), 10'd7);
    step(); idle();
    for (int b = 0; b < NB; b++) begin
      check_eq("multi_dout", 64'(bus1.dccm_bank_dout[b]), 64'(vals[b]));
      check_eq("multi_ecc", 64'(bus1.dccm_bank_ecc[b]), 64'(b + 1));
    end
    rd1(2'd0, 10'd5); wr1(2'd1, 10'd8, 32'hFFFF_FFFF, 7'h7F); step(); idle();
    check_eq("iso_rd0", 64'(bus1.dccm_bank_dout[0]), 64'hDEADBEEF);
    check_eq("iso_wr1_dout", 64'(bus1.dccm_bank_dout[1]), 64'(vals[1]));
    check_eq("iso_wr1_ecc", 64'(bus1.dccm_bank_ecc[1]), 64'h2);

    // Single-bit injection on bank1; bank0 read in between stays clean
    wr1(2'd0, 10'd0, 32'h55, 7'h0); wr1(2'd1, 10'd0, 32'h0, 7'h0); wr1(2'd3, 10'd0, 32'h0, 7'h0);
    step(); idle();
    arm(2'd1, 6'd3, 1'b0); step(); idle();
    check_eq("arm_busy", 64'(busy1), 64'h1);
    rd1(2'd0, 10'd0); step(); idle();
    check_eq("inj_other_bank", 64'(bus1.dccm_bank_dout[0]), 64'h55);
    check_eq("inj_other_done", 64'(done1), 64'h0);
    check_eq("inj_other_busy", 64'(busy1), 64'h1);
    rd1(2'd1, 10'd0); step(); idle();
    check_eq("inj1_dout", 64'(bus1.dccm_bank_dout[1]), 64'h8);
    check_eq("inj1_ecc", 64'(bus1.dccm_bank_ecc[1]), 64'h0);
    check_eq("inj1_done", 64'(done1), 64'h1);
    check_eq("inj1_busy", 64'(busy1), 64'h0);
    step();
    check_eq("inj1_done_pulse", 64'(done1), 64'h0);
    rd1(2'd1, 10'd0); step(); idle();
    check_eq("inj1_reread", 64'(bus1.dccm_bank_dout[1]), 64'h0);

    // Double-bit with wrap from bit 38 to bit 0; re-arm while armed ignored
    arm(2'd3, 6'd38, 1'b1); step(); idle();
    check_eq("arm2_busy", 64'(busy1), 64'h1);
    arm(2'd3, 6'd0, 1'b0); step(); idle();
    check_eq("arm2_still_busy", 64'(busy1), 64'h1);
    rd1(2'd3, 10'd0); step(); idle();
    check_eq("inj2_ecc", 64'(bus1.dccm_bank_ecc[3]), 64'h40);
    check_eq("inj2_dout", 64'(bus1.dccm_bank_dout[3]), 64'h1);
    check_eq("inj2_done", 64'(done1), 64'h1);

    // Bit index beyond the word consumes the read but flips nothing
    arm(2'd2, 6'd50, 1'b0); step(); idle();
    rd1(2'd2, 10'd7); step(); idle();
    check_eq("inj_oob_dout", 64'(bus1.dccm_bank_dout[2]), 64'(vals[2]));
    check_eq("inj_oob_ecc", 64'(bus1.dccm_bank_ecc[2]), 64'h3);
    check_eq("inj_oob_done", 64'(done1), 64'h1);
    check_eq("inj_oob_busy", 64'(busy1), 64'h0);

    // Read in the arm cycle is clean; the next read is corrupted
    arm(2'd0, 6'd0, 1'b0); rd1(2'd0, 10'd5); step(); idle();
    check_eq("arm_same_cycle", 64'(bus1.dccm_bank_dout[0]), 64'hDEADBEEF);
    check_eq("arm_same_busy", 64'(busy1), 64'h1);
    rd1(2'd0, 10'd5); step(); idle();
    check_eq("inj3_dout", 64'(bus1.dccm_bank_dout[0]), 64'hDEADBEEE);
    check_eq("inj3_done", 64'(done1), 64'h1);

    // Reset cancels an armed injection without done; storage survives
    arm(2'd0, 6'd0, 1'b0); step(); idle();
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("rstarm_busy", 64'(busy1), 64'h0);
    check_eq("rstarm_done", 64'(done1), 64'h0);
    check_eq("rstarm_dout0", 64'(bus1.dccm_bank_dout[0]), 64'h0);
    check_eq("rstarm_dout2", 64'(bus1.dccm_bank_dout[2]), 64'h0);
    rd1(2'd0, 10'd5); step(); idle();
    check_eq("rstarm_clean", 64'(bus1.dccm_bank_dout[0]), 64'hDEADBEEF);
    check_eq("rstarm_nodone", 64'(done1), 64'h0);

    // READ_LAT=3: ordered back-to-back reads on bank2
    for (int i = 1; i <= 3; i++) begin
      bus3.dccm_clken[2]        = 1'b1;
      bus3.dccm_wren_bank[2]    = 1'b1;
      bus3.dccm_addr_bank[2]    = 10'(i);
      bus3.dccm_wr_data_bank[2] = 32'hA000_0000 | 32'(i);
      bus3.dccm_wr_ecc_bank[2]  = 7'(i);
      step();
    end
    idle();
    rd3(10'd1); step();
    check_eq("lat3_c1", 64'(bus3.dccm_bank_dout[2]), 64'h0);
    rd3(10'd2); step();
    check_eq("lat3_c2", 64'(bus3.dccm_bank_dout[2]), 64'h0);
    rd3(10'd3); step(); idle();
    check_eq("lat3_w1", 64'(bus3.dccm_bank_dout[2]), 64'hA000_0001);
    check_eq("lat3_e1", 64'(bus3.dccm_bank_ecc[2]), 64'h1);
    step();
    check_eq("lat3_w2", 64'(bus3.dccm_bank_dout[2]), 64'hA000_0002);
    step();
    check_eq("lat3_w3", 64'(bus3.dccm_bank_dout[2]), 64'hA000_0003);
    step();
    check_eq("lat3_hold", 64'(bus3.dccm_bank_dout[2]), 64'hA000_0003);
    check_eq("lat3_hold_ecc", 64'(bus3.dccm_bank_ecc[2]), 64'h3);

    // Reset with a read in flight: discarded, contents kept
    rd3(10'd1); step(); idle();
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("lat3_rst_dout", 64'(bus3.dccm_bank_dout[2]), 64'h0);
    check_eq("lat3_rst_ecc", 64'(bus3.dccm_bank_ecc[2]), 64'h0);
    step(); step(); step();
    check_eq("lat3_flushed", 64'(bus3.dccm_bank_dout[2]), 64'h0);
    rd3(10'd2); step(); idle();
    step(); step();
    check_eq("lat3_kept", 64'(bus3.dccm_bank_dout[2]), 64'hA000_0002);
    check_eq("lat3_kept_ecc", 64'(bus3.dccm_bank_ecc[2]), 64'h2);
    check_eq("lat3_busy", 64'(busy3), 64'h0);
    check_eq("lat3_done", 64'(done3), 64'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
